// File: rtl/bram_capture_ctrl.sv
// Capture controller: optional threshold trigger, decimation, and packing of
// two 16-bit samples per 32-bit BRAM word, with done flag and interrupt.
module bram_capture_ctrl #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       i_data,
  input  logic              i_valid,
  input  logic              i_start,
  input  logic              i_trig_mode,
  input  logic [15:0]       i_trig_level,
  input  logic [31:0]       i_capture_len,
  input  logic [15:0]       i_decim,
  output logic [ADDR_W+1:0] o_bram_addr,
  output logic [31:0]       o_bram_din,
  output logic [3:0]        o_bram_we,
  output logic              o_bram_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_irq,
  output logic [31:0]       o_count
);

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

  localparam logic [31:0] MAX_LEN = 32'd1 << (ADDR_W + 1);

  state_t            state;
  logic [31:0]       len;
  logic [15:0]       decim;
  logic [15:0]       dcnt;
  logic [ADDR_W-1:0] word_idx;
  logic              half;
  logic [15:0]       first_s;
  logic [15:0]       prev;
  logic              prev_valid;
  logic              last_wr;

  logic        trig_hit;
  logic        dadv;
  logic        take;
  logic [31:0] cnt_next;
  logic        is_last;
  logic [31:0] len_in;

  always_comb begin
    len_in   = (i_capture_len > MAX_LEN) ? MAX_LEN : i_capture_len;
    trig_hit = (state == WAIT_TRIG) && i_valid && prev_valid &&
               ($signed(prev) < $signed(i_trig_level)) &&
               ($signed(i_data) >= $signed(i_trig_level));
    // The triggering sample is the first valid sample seen by the decimator.
    dadv     = trig_hit || ((state == CAPTURE) && !last_wr && i_valid);
    take     = dadv && (dcnt == 16'd0);
    cnt_next = o_count + 32'd1;
    is_last  = (cnt_next == len);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len         <= '0;
      decim       <= '0;
      dcnt        <= '0;
      word_idx    <= '0;
      half        <= 1'b0;
      first_s     <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
      last_wr     <= 1'b0;
      o_bram_addr <= '0;
      o_bram_din  <= '0;
      o_bram_we   <= '0;
      o_bram_en   <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_irq       <= 1'b0;
      o_count     <= '0;
    end else begin
      o_bram_en <= 1'b0;
      o_bram_we <= '0;
      o_irq     <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            len        <= len_in;
            decim      <= i_decim;
            o_count    <= '0;
            word_idx   <= '0;
            half       <= 1'b0;
            dcnt       <= '0;
            prev_valid <= 1'b0;
            last_wr    <= 1'b0;
            if (len_in == 32'd0) begin
              state  <= DONE;
              o_done <= 1'b1;
              o_irq  <= 1'b1;
              o_busy <= 1'b0;
            end else begin
              state  <= i_trig_mode ? WAIT_TRIG : CAPTURE;
              o_done <= 1'b0;
              o_busy <= 1'b1;
            end
          end
        end
        WAIT_TRIG: begin
          if (i_valid) begin
            prev       <= i_data;
            prev_valid <= 1'b1;
          end
          if (trig_hit) state <= CAPTURE;
        end
        CAPTURE: begin
          if (last_wr) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            o_irq  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (dadv) dcnt <= (dcnt == decim) ? 16'd0 : dcnt + 16'd1;

      if (take) begin
        o_count <= cnt_next;
        last_wr <= is_last;
        if (half || is_last) begin
          o_bram_en   <= 1'b1;
          o_bram_we   <= 4'hF;
          o_bram_addr <= {word_idx, 2'b00};
          o_bram_din  <= half ? {i_data, first_s} : {16'h0000, i_data};
          word_idx    <= word_idx + 1'b1;
          half        <= 1'b0;
        end else begin
          first_s <= i_data;
          half    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Directed bench for bram_capture_ctrl (ADDR_W=2 so the length clamp is reachable).
module tb_bram_capture_ctrl;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   i_data = '0;
  logic          i_valid = 1'b0;
  logic          i_start = 1'b0;
  logic          i_trig_mode = 1'b0;
  logic [15:0]   i_trig_level = '0;
  logic [31:0]   i_capture_len = '0;
  logic [15:0]   i_decim = '0;
  logic [AW+1:0] o_bram_addr;
  logic [31:0]   o_bram_din;
  logic [3:0]    o_bram_we;
  logic          o_bram_en;
  logic          o_busy;
  logic          o_done;
  logic          o_irq;
  logic [31:0]   o_count;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned irq_cnt = 0;
  logic [63:0] wq[$];

  bram_capture_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_start(i_start),
    .i_trig_mode(i_trig_mode), .i_trig_level(i_trig_level),
    .i_capture_len(i_capture_len), .i_decim(i_decim),
    .o_bram_addr(o_bram_addr), .o_bram_din(o_bram_din), .o_bram_we(o_bram_we),
    .o_bram_en(o_bram_en), .o_busy(o_busy), .o_done(o_done), .o_irq(o_irq),
    .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_bram_en) begin
      wq.push_back({32'(o_bram_addr), o_bram_din});
      check_val("we", 64'(o_bram_we), 64'hF);
    end
    if (o_irq) irq_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [31:0] len, input logic [15:0] dec,
                     input logic mode, input logic [15:0] lvl);
    i_capture_len = len;
    i_decim       = dec;
    i_trig_mode   = mode;
    i_trig_level  = lvl;
    i_start       = 1'b1;
    i_valid       = 1'b0;
    tick();
    i_start = 1'b0;
    wq.delete();
    irq_cnt = 0;
  endtask

  task automatic send(input logic [15:0] d);
    i_data  = d;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    i_valid = 1'b0;
    for (int unsigned k = 0; k < n; k++) tick();
  endtask

  task automatic wait_done();
    for (int k = 0; k < 30; k++) begin
      if (o_done) break;
      tick();
    end
    check_val("done_timeout", 64'(o_done), 64'd1);
    tick();
    tick();
  endtask

  task automatic check_wr(input string tag, input int unsigned idx,
                          input logic [31:0] addr, input logic [31:0] din);
    logic [63:0] w;
    w = (idx < wq.size()) ? wq[idx] : 64'hDEAD_DEAD_DEAD_DEAD;
    check_val(tag, w, {addr, din});
  endtask

  task automatic check_end(input string tag, input int unsigned nwr, input logic [31:0] cnt);
    check_val({tag, "_nwr"}, 64'(wq.size()), 64'(nwr));
    check_val({tag, "_irq"}, 64'(irq_cnt), 64'd1);
    check_val({tag, "_done"}, {62'd0, o_done, o_busy}, 64'h2);
    check_val({tag, "_count"}, 64'(o_count), 64'(cnt));
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_ctl"}, 64'({o_busy, o_done, o_irq, o_bram_en, o_bram_we, o_bram_addr}), 64'd0);
    check_val({tag, "_count"}, 64'(o_count), 64'd0);
    check_val({tag, "_din"}, 64'(o_bram_din), 64'd0);
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    #1;
    check_reset("reset");

    // 1: immediate, len 4
    arm(32'd4, 16'd0, 1'b0, 16'd0);
    check_val("t1_busy", 64'(o_busy), 64'd1);
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    wait_done();
    check_wr("t1_w0", 0, 32'd0, 32'h0002_0001);
    check_wr("t1_w1", 1, 32'd4, 32'h0004_0003);
    check_end("t1", 2, 32'd4);

    // 2: odd length pads upper half with zero
    arm(32'd3, 16'd0, 1'b0, 16'd0);
    send(16'h10); send(16'h20); send(16'h30);
    wait_done();
    check_wr("t2_w0", 0, 32'd0, 32'h0020_0010);
    check_wr("t2_w1", 1, 32'd4, 32'h0000_0030);
    check_end("t2", 2, 32'd3);

    // 3: trigger on rising crossing of 100
    arm(32'd2, 16'd0, 1'b1, 16'd100);
    send(16'hFFFB); send(16'd50); send(16'd99);
    check_val("t3_nowr_pre", 64'(wq.size()), 64'd0);
    send(16'd100); send(16'd120); send(16'd130);
    wait_done();
    check_wr("t3_w0", 0, 32'd0, 32'h0078_0064);
    check_end("t3", 1, 32'd2);

    // 3b: first valid sample after arming cannot trigger; 200 then 150 never crosses
    arm(32'd2, 16'd0, 1'b1, 16'd100);
    send(16'd200); send(16'd150); send(16'd300);
    idle(4);
    check_val("t3b_wait", {62'd0, o_busy, o_done}, 64'h2);
    check_val("t3b_nwr", 64'(wq.size()), 64'd0);
    rst = 1'b1; tick(); rst = 1'b0;

    // 4: decimate by 3, valid on alternate cycles
    arm(32'd2, 16'd2, 1'b0, 16'd0);
    for (int unsigned v = 0; v < 9; v++) begin
      send(16'(v));
      idle(1);
    end
    wait_done();
    check_wr("t4_w0", 0, 32'd0, 32'h0003_0000);
    check_end("t4", 1, 32'd2);

    // 5: reset mid-capture aborts, then a clean restart
    arm(32'd8, 16'd0, 1'b0, 16'd0);
    send(16'd1); send(16'd2); send(16'd3);
    check_val("t5_pre_count", 64'(o_count), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("t5_rst");
    wq.delete();
    irq_cnt = 0;
    send(16'd4); send(16'd5); idle(5);
    check_val("t5_nwr", 64'(wq.size()), 64'd0);
    check_val("t5_irq", 64'(irq_cnt), 64'd0);
    arm(32'd2, 16'd0, 1'b0, 16'd0);
    send(16'd7); send(16'd8);
    wait_done();
    check_wr("t5_w0", 0, 32'd0, 32'h0008_0007);
    check_end("t5", 1, 32'd2);

    // 6: length clamped to 8 samples; start mid-capture ignored
    arm(32'hFFFF_FFFF, 16'd0, 1'b0, 16'd0);
    send(16'd1); send(16'd2); send(16'd3);
    i_start = 1'b1;
    send(16'd4);
    i_start = 1'b0;
    for (int unsigned v = 5; v <= 10; v++) send(16'(v));
    wait_done();
    check_wr("t6_w0", 0, 32'd0,  32'h0002_0001);
    check_wr("t6_w1", 1, 32'd4,  32'h0004_0003);
    check_wr("t6_w2", 2, 32'd8,  32'h0006_0005);
    check_wr("t6_w3", 3, 32'd12, 32'h0008_0007);
    check_end("t6", 4, 32'd8);

    // 7: zero length goes straight to done
    arm(32'd0, 16'd0, 1'b0, 16'd0);
    send(16'd9);
    idle(2);
    check_end("t7", 0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
